// File: rtl/led_driver_rx_if.sv
// Serial-chain receive bundle: SCLK/LAT/SDO inputs, grayscale read port and decode results.
interface led_driver_rx_if #(
  parameter int unsigned LATCH_SIZE = 769
);
  logic                    sclk_in;
  logic                    lat_in;
  logic                    sdi;
  logic [5:0]              gs_rd_addr;
  logic [15:0]             gs_rd_data;
  logic [LATCH_SIZE-2:0]   ctrl_data;
  logic                    ctrl_valid;
  logic                    gs_valid;
  logic                    frame_err;
  logic                    magic_err;
  logic [15:0]             gs_frames;

  // Transmitter / checker side
  modport master (
    output sclk_in, lat_in, sdi, gs_rd_addr,
    input  gs_rd_data, ctrl_data, ctrl_valid, gs_valid, frame_err, magic_err, gs_frames
  );

  // Receiver side
  modport slave (
    input  sclk_in, lat_in, sdi, gs_rd_addr,
    output gs_rd_data, ctrl_data, ctrl_valid, gs_valid, frame_err, magic_err, gs_frames
  );
endinterface

// File: rtl/led_driver_rx.sv
// Receive-side decoder for one SDO lane of the LED-driver chain: shifts latch words,
// classifies them as control or grayscale frames and flags framing / magic errors.
module led_driver_rx #(
  parameter int unsigned LATCH_SIZE = 769,
  parameter int unsigned NUM_CH     = 48,
  parameter logic [7:0]  CTRL_MAGIC = 8'h96
) (
  input  logic           CLK_10M,
  input  logic           nReset,
  led_driver_rx_if.slave bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned CH_W   = 16;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  sclk_q, lat_q;
  logic                  sclk_rise, lat_rise;
  logic [LATCH_SIZE-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [LATCH_SIZE-1:0] snap_q;
  logic [CNT_W-1:0]      snap_cnt_q;
  logic [CH_W-1:0]       gs_q [NUM_CH];
  logic [LATCH_SIZE-2:0] ctrl_q;
  logic [15:0]           gs_frames_q;
  logic [CH_W-1:0]       gs_rd_q;
  logic                  ctrl_valid_q, ctrl_valid_d;
  logic                  gs_valid_q, gs_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  magic_err_q, magic_err_d;
  logic                  ctrl_load, gs_load;

  assign sclk_rise = bus.sclk_in & ~sclk_q;
  assign lat_rise  = bus.lat_in & ~lat_q;

  // Shift register and saturating bit counter; a latch restarts the count
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (lat_rise) begin
      bit_cnt_d = '0;
    end
    if (sclk_rise) begin
      shreg_d = {shreg_q[LATCH_SIZE-2:0], bus.sdi};
      if (lat_rise) begin
        bit_cnt_d = CNT_W'(1);
      end else if (bit_cnt_q != {CNT_W{1'b1}}) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and commit decision from the latched snapshot
  always_comb begin
    state_d      = state_q;
    frame_err_d  = 1'b0;
    ctrl_valid_d = 1'b0;
    gs_valid_d   = 1'b0;
    magic_err_d  = 1'b0;
    ctrl_load    = 1'b0;
    gs_load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lat_rise)  frame_err_d = 1'b1;
        if (sclk_rise) state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lat_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = sclk_rise ? ST_SHIFT : ST_IDLE;
        if (snap_cnt_q != CNT_W'(LATCH_SIZE)) begin
          frame_err_d = 1'b1;
        end else if (snap_q[LATCH_SIZE-1]) begin
          if (snap_q[LATCH_SIZE-2 -: 8] == CTRL_MAGIC) begin
            ctrl_valid_d = 1'b1;
            ctrl_load    = 1'b1;
          end else begin
            magic_err_d = 1'b1;
          end
        end else begin
          gs_valid_d = 1'b1;
          gs_load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_10M) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: edge history, shifter, snapshot, decoded registers and pulses
  always_ff @(posedge CLK_10M) begin
    if (!nReset) begin
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      snap_q       <= '0;
      snap_cnt_q   <= '0;
      ctrl_q       <= '0;
      gs_frames_q  <= '0;
      gs_rd_q      <= '0;
      ctrl_valid_q <= 1'b0;
      gs_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      magic_err_q  <= 1'b0;
      for (int ch = 0; ch < int'(NUM_CH); ch++) gs_q[ch] <= '0;
    end else begin
      sclk_q       <= bus.sclk_in;
      lat_q        <= bus.lat_in;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ctrl_valid_q <= ctrl_valid_d;
      gs_valid_q   <= gs_valid_d;
      frame_err_q  <= frame_err_d;
      magic_err_q  <= magic_err_d;
      if (lat_rise) begin
        snap_q     <= shreg_q;
        snap_cnt_q <= bit_cnt_q;
      end
      if (ctrl_load) ctrl_q <= snap_q[LATCH_SIZE-2:0];
      if (gs_load) begin
        for (int ch = 0; ch < int'(NUM_CH); ch++) gs_q[ch] <= snap_q[CH_W*ch +: CH_W];
        gs_frames_q <= gs_frames_q + 16'd1;
      end
      if (bus.gs_rd_addr < ADDR_W'(NUM_CH)) gs_rd_q <= gs_q[bus.gs_rd_addr];
      else                                  gs_rd_q <= '0;
    end
  end

  assign bus.gs_rd_data = gs_rd_q;
  assign bus.ctrl_data  = ctrl_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.gs_valid   = gs_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.magic_err  = magic_err_q;
  assign bus.gs_frames  = gs_frames_q;

endmodule
